eth_frame_len_filter: RTL and testbench
=======================================

Name: eth_frame_len_filter

Overview:
- AXI-Stream frame length policer placed directly downstream of the per-port frame FIFO, in the same clock domain and at the same DATA_WIDTH/ID_WIDTH.
- Drops runt frames shorter than MIN_BYTES and truncates frames longer than MAX_BYTES.
- Buffers only the head of each frame until its length is proven, then cuts through at full rate.
- Maintains saturating drop and truncation counters for the speed-tester status registers.

Parameters:
DATA_WIDTH, 64, stream data width in bits; multiple of 8
ID_WIDTH, 3, width of the frame id (port) sideband
MIN_BYTES, 60, frames with fewer bytes are discarded; 1..MAX_BYTES
MAX_BYTES, 1514, frames with more bytes are cut to exactly this length
HOLD_BEATS, ceil(MIN_BYTES/(DATA_WIDTH/8)), derived; beats needed to prove MIN_BYTES; buffer DEPTH = 2*HOLD_BEATS (power of two; round up)

Ports:
clk  in  1  stream clock
reset_n  in  1  asynchronous active-low reset
s_data  in  DATA_WIDTH  input beat data
s_keep  in  DATA_WIDTH/8  byte enables; contiguous from bit 0; all ones unless s_last
s_last  in  1  last beat of frame
s_user  in  DATA_WIDTH/8  per-byte user flags; passed through
s_id  in  ID_WIDTH  frame id; constant within a frame
s_valid  in  1  input valid
s_ready  out  1  input ready
m_data  out  DATA_WIDTH  output data
m_keep  out  DATA_WIDTH/8  output byte enables
m_last  out  1  output last
m_user  out  DATA_WIDTH/8  output user
m_id  out  ID_WIDTH  output id
m_valid  out  1  output valid
m_ready  in  1  output ready
drop_count  out  32  runt frames discarded; saturates at 0xFFFFFFFF
trunc_count  out  32  frames truncated; saturates at 0xFFFFFFFF

Behaviour:
- Reset (reset_n low, asynchronous): all pointers 0; state ACCUM; byte_cnt 0; m_valid 0; s_ready 0 while asserted; both counters 0. On release, s_ready rises on the first clock edge.
- Storage: circular buffer of DEPTH entries {data, keep, last, user, id}.
  - Pointers are one bit wider than the address: wr_ptr, rd_ptr, commit_ptr, start_ptr.
  - Output presents the entry at rd_ptr. m_valid = (rd_ptr != commit_ptr).
  - rd_ptr increments on m_valid & m_ready.
  - Outputs come straight from the storage read port; no extra register stage.
- s_ready = (state == SKIP) | ((wr_ptr - rd_ptr) < DEPTH). Accept = s_valid & s_ready.
- byte_cnt (11+ bits) = bytes of the current frame accepted so far; beat bytes = popcount(s_keep). new_cnt = byte_cnt + beat bytes.
- State ACCUM (frame length not yet proven):
  - Accepted beats are written at wr_ptr; wr_ptr advances; commit_ptr holds at start_ptr.
  - If new_cnt >= MIN_BYTES, set commit_ptr = wr_ptr + 1 in the same edge. The first output beat is then valid 1 cycle after the proving beat is accepted. Go to PASS, or handle as PASS-last if s_last.
  - Else if s_last: runt. wr_ptr <= start_ptr (the whole frame is discarded); drop_count++; byte_cnt <= 0; stay in ACCUM.
- State PASS: each accepted beat is written and committed in the same edge (commit_ptr = wr_ptr + 1).
  - If new_cnt > MAX_BYTES: write the beat with keep trimmed so the frame totals exactly MAX_BYTES, and force last = 1; trunc_count++.
    - If s_last was 0, go to SKIP; otherwise go to ACCUM.
    - A beat that would have 0 remaining bytes cannot occur, because the previous beat already ended the frame (see next rule).
  - If new_cnt == MAX_BYTES and not s_last: force last = 1 and go to SKIP; trunc_count++.
- State SKIP: s_ready = 1; accepted beats are discarded; on s_last go to ACCUM.
- Frame end (any accepted last, including forced): byte_cnt <= 0; start_ptr <= wr_ptr after the write.
  - Back-to-back frames are accepted without bubbles, since the buffer holds 2*HOLD_BEATS.
- Simultaneous write and read on the same cycle are both honoured. A runt rollback never touches committed entries.
- Counters saturate and never wrap. m_* payload is unchanged except for truncation keep/last.

Test Plan:
- 64-byte frame (8 full beats), m_ready = 1 -> out 8 beats identical to input; first m_valid 1 cycle after beat 8 accepted; counters stay 0.
- 40-byte frame (keep 0xFF x4, 0xFF at last), then a 64-byte frame -> first frame absent on output; drop_count = 1; second frame output intact.
- 1600-byte frame -> output 190 beats: 189 full beats, then last beat keep 0x03 with m_last = 1 (total 1514 bytes); remaining input accepted with no output; trunc_count = 1.
- Exactly 1514-byte and exactly 60-byte frames -> both passed unmodified; counters stay 0.
- Continuous 64-byte frames with m_ready = 1 -> s_ready stays 1 in steady state; full throughput, no gaps. With m_ready = 0, s_ready falls after 16 beats are accepted.
- reset_n asserted mid-frame, then a new 64-byte frame -> m_valid = 0 immediately; counters = 0; the new frame passes intact.

Source files
------------

// File: rtl/eth_frame_len_filter.sv
// AXI-Stream frame length policer: discards runt frames, truncates oversize frames,
// and holds only the frame head until its minimum length is proven.
module eth_frame_len_filter #(
  parameter int DATA_WIDTH = 64,
  parameter int ID_WIDTH   = 3,
  parameter int MIN_BYTES  = 60,
  parameter int MAX_BYTES  = 1514
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic [DATA_WIDTH-1:0]   s_data,
  input  logic [DATA_WIDTH/8-1:0] s_keep,
  input  logic                    s_last,
  input  logic [DATA_WIDTH/8-1:0] s_user,
  input  logic [ID_WIDTH-1:0]     s_id,
  input  logic                    s_valid,
  output logic                    s_ready,
  output logic [DATA_WIDTH-1:0]   m_data,
  output logic [DATA_WIDTH/8-1:0] m_keep,
  output logic                    m_last,
  output logic [DATA_WIDTH/8-1:0] m_user,
  output logic [ID_WIDTH-1:0]     m_id,
  output logic                    m_valid,
  input  logic                    m_ready,
  output logic [31:0]             drop_count,
  output logic [31:0]             trunc_count
);

  localparam int BYTES      = DATA_WIDTH / 8;
  localparam int HOLD_BEATS = (MIN_BYTES + BYTES - 1) / BYTES;
  localparam int AW         = $clog2(2 * HOLD_BEATS);
  localparam int DEPTH      = 1 << AW;
  localparam int CNT_RAW    = $clog2(MAX_BYTES + BYTES + 1);
  localparam int CNT_W      = (CNT_RAW > 11) ? CNT_RAW : 11;
  localparam int BC_W       = $clog2(BYTES + 1);

  typedef enum logic [1:0] {ACCUM, PASS, SKIP} state_t;

  typedef struct packed {
    logic [DATA_WIDTH-1:0] data;
    logic [BYTES-1:0]      keep;
    logic                  last;
    logic [BYTES-1:0]      user;
    logic [ID_WIDTH-1:0]   id;
  } entry_t;

  state_t           state, state_nxt;
  logic [AW:0]      wr_ptr, rd_ptr, commit_ptr, start_ptr;
  logic [AW:0]      occupancy;
  logic [CNT_W-1:0] byte_cnt, new_cnt, remaining;
  logic [BC_W-1:0]  beat_bytes;
  logic [BYTES-1:0] keep_trim;
  logic             ready_en;
  logic             accept, passing, over, at_max, trunc, frame_end, runt;
  entry_t           wr_entry, rd_entry;
  entry_t           mem [DEPTH];

  assign occupancy = wr_ptr - rd_ptr;
  assign s_ready   = ready_en & ((state == SKIP) | (occupancy < (AW+1)'(DEPTH)));
  assign accept    = s_valid & s_ready;
  assign new_cnt   = byte_cnt + CNT_W'(beat_bytes);
  assign remaining = CNT_W'(MAX_BYTES) - byte_cnt;
  assign passing   = (state == PASS) | ((state == ACCUM) & (new_cnt >= CNT_W'(MIN_BYTES)));
  assign over      = new_cnt > CNT_W'(MAX_BYTES);
  assign at_max    = new_cnt == CNT_W'(MAX_BYTES);
  assign trunc     = accept & passing & (over | (at_max & ~s_last));
  assign frame_end = accept & passing & (s_last | trunc);
  assign runt      = accept & (state == ACCUM) & ~passing & s_last;

  // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    beat_bytes = '0;
    keep_trim  = '0;
    for (int i = 0; i < BYTES; i++) begin
      beat_bytes   = beat_bytes + BC_W'(s_keep[i]);
      keep_trim[i] = s_keep[i] & (CNT_W'(i) < remaining);
    end
  end

  always_comb begin
    wr_entry = '{data: s_data, keep: s_keep, last: s_last, user: s_user, id: s_id};
    if (passing && over) begin
      wr_entry.keep = keep_trim;
      wr_entry.last = 1'b1;
    end else if (passing && at_max) begin
      wr_entry.last = 1'b1;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ACCUM, PASS: begin
        if (accept && passing) begin
          if (trunc && !s_last) state_nxt = SKIP;
          else if (s_last)      state_nxt = ACCUM;
          else                  state_nxt = PASS;
        end
      end
      SKIP:    if (accept && s_last) state_nxt = ACCUM;
      default: state_nxt = ACCUM;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state       <= ACCUM;
      ready_en    <= 1'b0;
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      commit_ptr  <= '0;
      start_ptr   <= '0;
      byte_cnt    <= '0;
      drop_count  <= '0;
      trunc_count <= '0;
    end else begin
      state    <= state_nxt;
      ready_en <= 1'b1;
      if (m_valid && m_ready) rd_ptr <= rd_ptr + (AW+1)'(1);
      if (runt)                                wr_ptr <= start_ptr;
      else if (accept && (state != SKIP))      wr_ptr <= wr_ptr + (AW+1)'(1);
      if (accept && passing)                   commit_ptr <= wr_ptr + (AW+1)'(1);
      if (frame_end)                           start_ptr  <= wr_ptr + (AW+1)'(1);
      if (accept) begin
        if (runt || frame_end || (state == SKIP)) byte_cnt <= '0;
        else                                      byte_cnt <= new_cnt;
      end
      if (runt && (drop_count != '1))   drop_count  <= drop_count + 32'd1;
      if (trunc && (trunc_count != '1)) trunc_count <= trunc_count + 32'd1;
    end
  end

  // NOTE: the storage array is deliberately not reset; pointers alone define which entries are live.
  always_ff @(posedge clk) begin
    if (accept && (state != SKIP)) mem[wr_ptr[AW-1:0]] <= wr_entry;
  end

  assign rd_entry = mem[rd_ptr[AW-1:0]];
  assign m_valid  = rd_ptr != commit_ptr;
  assign m_data   = rd_entry.data;
  assign m_keep   = rd_entry.keep;
  assign m_last   = rd_entry.last;
  assign m_user   = rd_entry.user;
  assign m_id     = rd_entry.id;

endmodule

// File: tb/tb_eth_frame_len_filter.sv
// Self-checking bench for eth_frame_len_filter: directed boundary frames plus randomized
// traffic, checked against a frame-level model that emits the first MAX_BYTES of each legal frame.
module tb_eth_frame_len_filter;

  localparam int MIN_B = 60;
  localparam int MAX_B = 1514;

  typedef struct packed {
    logic [63:0] data;
    logic [7:0]  keep;
    logic        last;
    logic [7:0]  user;
    logic [2:0]  id;
  } beat_t;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [63:0] s_data = '0;
  logic [7:0]  s_keep = '0;
  logic        s_last = 1'b0;
  logic [7:0]  s_user = '0;
  logic [2:0]  s_id = '0;
  logic        s_valid = 1'b0;
  logic        s_ready;
  logic [63:0] m_data;
  logic [7:0]  m_keep;
  logic        m_last;
  logic [7:0]  m_user;
  logic [2:0]  m_id;
  logic        m_valid;
  logic        m_ready = 1'b0;
  logic [31:0] drop_count, trunc_count;

  int    vectors = 0;
  int    miscompares = 0;
  int    stalls = 0;
  int    ready_mode = 1;
  bit    gap_en = 0;
  int    exp_drop = 0;
  int    exp_trunc = 0;
  beat_t frm_q[$];
  beat_t exp_q[$];

  eth_frame_len_filter dut (
    .clk(clk), .reset_n(reset_n),
    .s_data(s_data), .s_keep(s_keep), .s_last(s_last), .s_user(s_user), .s_id(s_id),
    .s_valid(s_valid), .s_ready(s_ready),
    .m_data(m_data), .m_keep(m_keep), .m_last(m_last), .m_user(m_user), .m_id(m_id),
    .m_valid(m_valid), .m_ready(m_ready),
    .drop_count(drop_count), .trunc_count(trunc_count)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    #1;
    case (ready_mode)
      0:       m_ready = 1'b0;
      1:       m_ready = 1'b1;
      default: m_ready = 1'($urandom_range(0, 1));
    endcase
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  always @(negedge clk) begin
    if (reset_n && m_valid && m_ready) begin
      if (exp_q.size() == 0) begin
        check("unexpected output beat", 64'd1, 64'd0);
      end else begin
        beat_t e;
        e = exp_q.pop_front();
        check("m_data", m_data, e.data);
        check("m_keep", 64'(m_keep), 64'(e.keep));
        check("m_last", 64'(m_last), 64'(e.last));
        check("m_user", 64'(m_user), 64'(e.user));
        check("m_id",   64'(m_id),   64'(e.id));
      end
    end
  end

  task automatic build_frame(input int nbytes, input logic [2:0] id);
    int nb;
    frm_q.delete();
    nb = (nbytes + 7) / 8;
    for (int b = 0; b < nb; b++) begin
      beat_t bt;
      int here;
      here    = (b == nb - 1) ? nbytes - 8 * b : 8;
      bt.data = {$urandom, $urandom};
      bt.keep = 8'((9'd1 << here) - 9'd1);
      bt.last = (b == nb - 1);
      bt.user = 8'($urandom);
      bt.id   = id;
      frm_q.push_back(bt);
    end
  endtask

  // Legal frames come out as their first MAX_B bytes; runts vanish.
  task automatic model_frame(input int nbytes);
    int emitted = 0;
    if (nbytes < MIN_B) begin
      exp_drop++;
      return;
    end
    if (nbytes > MAX_B) exp_trunc++;
    foreach (frm_q[b]) begin
      beat_t ob;
      int have, take;
      ob   = frm_q[b];
      have = $countones(ob.keep);
      take = (MAX_B - emitted < have) ? MAX_B - emitted : have;
      ob.keep = 8'((9'd1 << take) - 9'd1);
      ob.last = ob.last | (emitted + take == MAX_B);
      emitted += take;
      exp_q.push_back(ob);
      if (ob.last) break;
    end
  endtask

  task automatic send_beat(input beat_t bt);
    int waited = 0;
    s_data = bt.data; s_keep = bt.keep; s_last = bt.last;
    s_user = bt.user; s_id = bt.id; s_valid = 1'b1;
    while (!s_ready) begin
      @(negedge clk);
      stalls++;
      waited++;
      if (waited > 5000) begin
        check("s_ready timeout", 64'd0, 64'd1);
        s_valid = 1'b0;
        return;
      end
    end
    @(posedge clk);
    #1;
    s_valid = 1'b0;
  endtask

  task automatic send_frame(input int nbytes, input bit modeled);
    build_frame(nbytes, 3'($urandom));
    if (modeled) model_frame(nbytes);
    foreach (frm_q[b]) begin
      if (gap_en && $urandom_range(0, 3) == 0) begin
        @(posedge clk);
        #1;
      end
      send_beat(frm_q[b]);
    end
  endtask

  task automatic drain();
    int n = 0;
    ready_mode = 1;
    while ((exp_q.size() != 0 || m_valid) && n < 3000) begin
      @(negedge clk);
      n++;
    end
    @(negedge clk);
    check("drain exp_q empty", 64'(exp_q.size()), 64'd0);
  endtask

  initial begin
    // Reset values
    #12;
    check("reset s_ready", 64'(s_ready), 64'd0);
    check("reset m_valid", 64'(m_valid), 64'd0);
    check("reset drop_count", 64'(drop_count), 64'd0);
    check("reset trunc_count", 64'(trunc_count), 64'd0);
    @(negedge clk);
    reset_n = 1'b1;
    #1;
    check("s_ready before first edge", 64'(s_ready), 64'd0);
    @(posedge clk);
    #1;
    check("s_ready after first edge", 64'(s_ready), 64'd1);

    // 64-byte frame: first m_valid exactly one cycle after beat 8
    build_frame(64, 3'd5);
    model_frame(64);
    foreach (frm_q[b]) begin
      send_beat(frm_q[b]);
      @(negedge clk);
      check($sformatf("latency m_valid after beat %0d", b + 1), 64'(m_valid), 64'(b == 7));
    end
    drain();
    check("64B drop_count", 64'(drop_count), 64'd0);
    check("64B trunc_count", 64'(trunc_count), 64'd0);

    // Runt then a good frame
    send_frame(40, 1);
    send_frame(64, 1);
    drain();
    check("runt drop_count", 64'(drop_count), 64'(exp_drop));

    // Oversize frame
    send_frame(1600, 1);
    drain();
    check("1600B trunc_count", 64'(trunc_count), 64'(exp_trunc));

    // Exact boundaries pass unmodified
    send_frame(MAX_B, 1);
    send_frame(MIN_B, 1);
    send_frame(MIN_B - 1, 1);
    drain();
    check("boundary drop_count", 64'(drop_count), 64'(exp_drop));
    check("boundary trunc_count", 64'(trunc_count), 64'(exp_trunc));

    // Continuous 64-byte frames at full rate
    stalls = 0;
    for (int f = 0; f < 6; f++) send_frame(64, 1);
    check("throughput stalls", 64'(stalls), 64'd0);
    drain();

    // Backpressure: 16 beats fill the buffer
    ready_mode = 0;
    @(posedge clk);
    #2;
    stalls = 0;
    send_frame(64, 1);
    send_frame(64, 1);
    check("fill stalls", 64'(stalls), 64'd0);
    check("s_ready low when full", 64'(s_ready), 64'd0);
    check("m_valid when full", 64'(m_valid), 64'd1);
    drain();

    // Randomized traffic
    ready_mode = 2;
    gap_en = 1;
    for (int f = 0; f < 30; f++) begin
      int r, len;
      r = $urandom_range(0, 9);
      if (r < 6)      len = $urandom_range(1, 200);
      else if (r < 8) len = $urandom_range(1400, 1700);
      else            len = $urandom_range(MIN_B - 5, MIN_B + 5);
      send_frame(len, 1);
    end
    gap_en = 0;
    drain();
    check("random drop_count", 64'(drop_count), 64'(exp_drop));
    check("random trunc_count", 64'(trunc_count), 64'(exp_trunc));

    // Reset mid-frame
    ready_mode = 0;
    @(posedge clk);
    #2;
    send_frame(64, 0);
    build_frame(64, 3'd2);
    for (int b = 0; b < 3; b++) send_beat(frm_q[b]);
    check("m_valid before reset", 64'(m_valid), 64'd1);
    #2;
    reset_n = 1'b0;
    #1;
    check("mid reset m_valid", 64'(m_valid), 64'd0);
    check("mid reset s_ready", 64'(s_ready), 64'd0);
    check("mid reset drop_count", 64'(drop_count), 64'd0);
    check("mid reset trunc_count", 64'(trunc_count), 64'd0);
    exp_q.delete();
    exp_drop = 0;
    exp_trunc = 0;
    @(negedge clk);
    reset_n = 1'b1;
    ready_mode = 1;
    @(posedge clk);
    #1;
    send_frame(64, 1);
    drain();
    check("post reset drop_count", 64'(drop_count), 64'd0);
    check("post reset trunc_count", 64'(trunc_count), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #5000000;
    check("global time limit", 64'd0, 64'd1);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $fatal(1, "FAIL global time limit reached");
  end

endmodule
